// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus bundles for mem_access_unit.
//   mem_req_if : pipeline side. master = MEM stage (drives req_*),
//                slave = mem_access_unit (drives req_ready, resp_*).
//   mem_bus_if : data-memory side. master = mem_access_unit (drives
//                mem_adr/mem_datain/mem_w/mem_r), slave = memory (drives
//                mem_dataout).
interface mem_req_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_done;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_done, resp_rdata, resp_fault
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_done, resp_rdata, resp_fault
    );
endinterface

interface mem_bus_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] mem_adr;
    logic [XLEN-1:0] mem_datain;
    logic            mem_w;
    logic            mem_r;
    logic [XLEN-1:0] mem_dataout;

    modport master (
        output mem_adr, mem_datain, mem_w, mem_r,
        input  mem_dataout
    );
    modport slave (
        input  mem_adr, mem_datain, mem_w, mem_r,
        output mem_dataout
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a byte-addressed 64-bit data
// memory. Accepts one B/H/W/D load or store per handshake and always issues
// doubleword-aligned memory cycles. Sub-doubleword stores are read-modify-
// write; loads are lane-extracted and sign/zero-extended.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req        : mem_req_if.slave  - request handshake and completion pulse
//   bus        : mem_bus_if.master - aligned memory read/write cycles
module mem_access_unit #(
    parameter int MEM_BYTES = 32,
    parameter int XLEN      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_req_if.slave   req,
    mem_bus_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RMW_RD, S_WR, S_RMW_WR, S_RESP
    } state_e;

    state_e          state_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [2:0]      lane_q;
    logic [XLEN-1:0] wdata_q;

    logic            mem_r_q, mem_w_q;
    logic [XLEN-1:0] mem_adr_q, mem_datain_q;
    logic            done_q, fault_q;
    logic [XLEN-1:0] rdata_q;

    // Low-order byte mask for an access of the given size.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        m = '1;
        case (sz)
            2'd0:    m = XLEN'(64'h0000_0000_0000_00FF);
            2'd1:    m = XLEN'(64'h0000_0000_0000_FFFF);
            2'd2:    m = XLEN'(64'h0000_0000_FFFF_FFFF);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Accept-time decode on the live request fields.
    logic [2:0]      acc_lane;
    logic [XLEN-1:0] acc_aligned;
    logic [2:0]      acc_lane_mask;
    logic            acc_fault;

    assign acc_lane    = req.req_addr[2:0];
    assign acc_aligned = {req.req_addr[XLEN-1:3], 3'b000};

    always_comb begin
        acc_lane_mask = 3'd0;
        case (req.req_size)
            2'd0:    acc_lane_mask = 3'd0;
            2'd1:    acc_lane_mask = 3'd1;
            2'd2:    acc_lane_mask = 3'd3;
            default: acc_lane_mask = 3'd7;
        endcase
    end

    // Comparing against MEM_BYTES-8 avoids the wrap of aligned+8 at the top
    // of the address space.
    assign acc_fault = ((acc_lane & acc_lane_mask) != 3'd0) ||
                       (acc_aligned > XLEN'(MEM_BYTES - 8));

    // Load extraction and RMW merge on the latched lane/size.
    logic [5:0]      shamt;
    logic [XLEN-1:0] fmask, field, extracted, merged;
    logic            sign_bit;

    assign shamt = {lane_q, 3'b000};
    assign fmask = size_mask(size_q);
    assign field = (bus.mem_dataout >> shamt) & fmask;

    always_comb begin
        sign_bit = 1'b0;
        case (size_q)
            2'd0:    sign_bit = field[7];
            2'd1:    sign_bit = field[15];
            2'd2:    sign_bit = field[31];
            default: sign_bit = 1'b0;   // D has nothing to extend
        endcase
    end

    assign extracted = (!uns_q && sign_bit) ? (field | ~fmask) : field;
    assign merged    = (bus.mem_dataout & ~(fmask << shamt)) |
                       ((wdata_q & fmask) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            lane_q       <= 3'd0;
            wdata_q      <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            mem_adr_q    <= '0;
            mem_datain_q <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req.req_valid) begin
                        size_q  <= req.req_size;
                        uns_q   <= req.req_unsigned;
                        lane_q  <= acc_lane;
                        wdata_q <= req.req_wdata;
                        if (acc_fault) begin
                            // No memory cycle; complete on the next cycle.
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            mem_adr_q <= acc_aligned;
                            if (!req.req_we) begin
                                state_q <= S_RD;
                                mem_r_q <= 1'b1;
                            end else if (req.req_size == 2'd3) begin
                                state_q      <= S_WR;
                                mem_w_q      <= 1'b1;
                                mem_datain_q <= req.req_wdata;
                            end else begin
                                state_q <= S_RMW_RD;
                                mem_r_q <= 1'b1;
                            end
                        end
                    end
                end
                S_RD: begin
                    mem_r_q <= 1'b0;
                    rdata_q <= extracted;
                    done_q  <= 1'b1;
                    fault_q <= 1'b0;
                    state_q <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_r_q      <= 1'b0;
                    mem_w_q      <= 1'b1;
                    mem_datain_q <= merged;
                    state_q      <= S_RMW_WR;
                end
                S_WR, S_RMW_WR: begin
                    mem_w_q <= 1'b0;
                    rdata_q <= '0;
                    done_q  <= 1'b1;
                    fault_q <= 1'b0;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req.req_ready  = (state_q == S_IDLE);
    assign req.resp_done  = done_q;
    assign req.resp_fault = fault_q;
    assign req.resp_rdata = rdata_q;
    assign bus.mem_adr    = mem_adr_q;
    assign bus.mem_datain = mem_datain_q;
    assign bus.mem_r      = mem_r_q;
    assign bus.mem_w      = mem_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts
// each response at issue time; a negedge monitor pops and compares on every
// resp_done. A separate byte-array memory answers the DUT's bus cycles.
module tb_mem_access_unit;
    localparam int MEMB = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_if #(.XLEN(64)) req_if ();
    mem_bus_if #(.XLEN(64)) bus_if ();

    mem_access_unit #(.MEM_BYTES(MEMB), .XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_if),
        .bus   (bus_if)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nr = 0, nw = 0;
    logic [63:0] last_adr = 64'd0;
    logic [7:0] mem [0:MEMB-1];
    logic [7:0] ref_mem [0:MEMB-1];
    logic mem_loaded = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: read data is combinational; an idle bus returns a junk pattern
    // so any capture outside a read cycle shows up as wrong data.
    always_comb begin
        bus_if.mem_dataout = 64'hDEAD_BEEF_DEAD_BEEF;
        if (bus_if.mem_r && bus_if.mem_adr <= 64'(MEMB - 8))
            for (int i = 0; i < 8; i++)
                bus_if.mem_dataout[8*i +: 8] = mem[int'(bus_if.mem_adr[4:0]) + i];
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'h00;
            mem[0]  <= 8'h14;
            mem[2]  <= 8'h32;
            mem[12] <= 8'h64;
            mem_loaded <= 1'b1;
        end else if (bus_if.mem_w && bus_if.mem_adr <= 64'(MEMB - 8)) begin
            for (int i = 0; i < 8; i++)
                mem[int'(bus_if.mem_adr[4:0]) + i] <= bus_if.mem_datain[8*i +: 8];
        end
    end

    // Bus protocol sampling and access counters.
    always @(negedge clk) begin
        if (rst_n && (bus_if.mem_r || bus_if.mem_w)) begin
            chk("rw_exclusive", {63'd0, bus_if.mem_r & bus_if.mem_w}, 64'd0);
            chk("adr_aligned", {61'd0, bus_if.mem_adr[2:0]}, 64'd0);
            chk("adr_in_range", {63'd0, bus_if.mem_adr > 64'(MEMB - 8)}, 64'd0);
            if (bus_if.mem_r) nr++;
            if (bus_if.mem_w) nw++;
            last_adr = bus_if.mem_adr;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && req_if.resp_done) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: got resp_done with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", req_if.resp_rdata, e.rdata);
                chk("fault", {63'd0, req_if.resp_fault}, {63'd0, e.fault});
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                chk("ready_low_in_resp", {63'd0, req_if.req_ready}, 64'd0);
            end
        end
    end

    // Reference model: architectural effect of one request on ref_mem.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, output exp_t e);
        int n, lane, base;
        logic [63:0] al, v;
        n = 1 << sz;
        lane = int'(addr[2:0]);
        al = {addr[63:3], 3'b000};
        e.fault = ((lane % n) != 0) || (({1'b0, al} + 65'd8) > 65'(MEMB));
        e.rdata = 64'd0;
        e.acc = 0;
        if (e.fault) begin
            e.lat = 1;
        end else begin
            base = int'(al[4:0]) + lane;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
                e.lat = (sz == 2'd3) ? 2 : 3;
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
                if (!uns && n < 8 && v[8*n-1])
                    for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
                e.lat = 2;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input int gap);
        exp_t e;
        int t;
        req_if.req_valid = 1'b1;
        req_if.req_we = we;
        req_if.req_size = sz;
        req_if.req_unsigned = uns;
        req_if.req_addr = addr;
        req_if.req_wdata = wd;
        t = 0;
        while (!req_if.req_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                checks++; failures++;
                $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
                req_if.req_valid = 1'b0;
                return;
            end
        end
        model(we, sz, uns, addr, wd, e);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (gap > 0) begin
            req_if.req_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        req_if.req_valid = 1'b0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", {63'd0, q.size() != 0}, 64'd0);
        @(negedge clk);
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < MEMB; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                failures++;
                $display("FAIL mem_%s[%0d]: got %h expected %h", tag, i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        logic [1:0] sz;
        logic [63:0] a;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h14; ref_mem[2] = 8'h32; ref_mem[12] = 8'h64;
        req_if.req_valid = 1'b0; req_if.req_we = 1'b0; req_if.req_size = 2'd0;
        req_if.req_unsigned = 1'b0; req_if.req_addr = 64'd0; req_if.req_wdata = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, req_if.req_ready}, 64'd1);
        chk("rst_done", {63'd0, req_if.resp_done}, 64'd0);
        chk("rst_fault", {63'd0, req_if.resp_fault}, 64'd0);
        chk("rst_rdata", req_if.resp_rdata, 64'd0);
        chk("rst_mem_rw", {62'd0, bus_if.mem_r, bus_if.mem_w}, 64'd0);
        chk("rst_mem_adr", bus_if.mem_adr, 64'd0);
        chk("rst_mem_datain", bus_if.mem_datain, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sequence.
        send(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, 1);        // D load -> 0x320014
        send(1'b0, 2'd0, 1'b0, 64'd12, 64'd0, 1);       // B load signed -> 0x64
        drain();
        r0 = nr; w0 = nw;
        send(1'b1, 2'd0, 1'b0, 64'd12, 64'hF0, 1);      // B store via RMW
        drain();
        chk("rmw_b_reads", 64'(nr - r0), 64'd1);
        chk("rmw_b_writes", 64'(nw - w0), 64'd1);
        chk("rmw_b_adr", last_adr, 64'd8);
        send(1'b0, 2'd0, 1'b0, 64'd12, 64'd0, 1);       // -> FFFF_FFFF_FFFF_FFF0
        send(1'b0, 2'd0, 1'b1, 64'd12, 64'd0, 1);       // -> F0
        send(1'b1, 2'd1, 1'b0, 64'd2, 64'hBEEF, 1);     // H store at 2
        send(1'b0, 2'd2, 1'b1, 64'd0, 64'd0, 1);        // W load -> BEEF_0014
        drain();
        compare_mem("after_h_store");
        r0 = nr; w0 = nw;
        send(1'b0, 2'd1, 1'b0, 64'd3, 64'd0, 1);        // misaligned H -> fault
        send(1'b0, 2'd3, 1'b0, 64'd32, 64'd0, 1);       // out of range -> fault
        drain();
        chk("fault_no_access", 64'((nr - r0) + (nw - w0)), 64'd0);
        r0 = nr; w0 = nw;
        send(1'b1, 2'd3, 1'b0, 64'd24, 64'h0123_4567_89AB_CDEF, 1);
        drain();
        chk("d_store_writes", 64'(nw - w0), 64'd1);
        chk("d_store_reads", 64'(nr - r0), 64'd0);
        chk("d_store_adr", last_adr, 64'd24);

        // Reset during RMW_RD of a store H at 16: the store must vanish.
        w0 = nw;
        req_if.req_valid = 1'b1; req_if.req_we = 1'b1; req_if.req_size = 2'd1;
        req_if.req_unsigned = 1'b0; req_if.req_addr = 64'd16; req_if.req_wdata = 64'hA5A5;
        @(posedge clk);
        @(negedge clk);
        chk("rmw_rd_active", {63'd0, bus_if.mem_r}, 64'd1);
        rst_n = 1'b0;
        req_if.req_valid = 1'b0;
        #1;
        chk("abort_ready", {63'd0, req_if.req_ready}, 64'd1);
        chk("abort_mem_rw", {62'd0, bus_if.mem_r, bus_if.mem_w}, 64'd0);
        chk("abort_done", {63'd0, req_if.resp_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_write", 64'(nw - w0), 64'd0);
        compare_mem("after_abort");

        // req_valid held high, alternating load and store.
        for (int i = 0; i < 20; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, 3) * 8 + ((($urandom_range(0, 7)) >> sz) << sz));
            send(1'(i % 2), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 0);
        end
        drain();

        // Randomized mix, including faults and gaps.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'($urandom_range(0, MEMB + 7));
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, {$urandom, $urandom}, $urandom_range(0, 2));
        end
        drain();
        compare_mem("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator for the byte-addressed 64-bit data memory: the requester side of its r/w/adr/datain/dataout interface.
- Sits between the pipeline MEM stage and the data memory.
- Takes one load or store per handshake, sized B/H/W/D, and always issues doubleword-aligned memory accesses.
- Sub-doubleword stores are done as read-modify-write; loads are lane-extracted and sign- or zero-extended.

Parameters:
- MEM_BYTES, 32, memory size in bytes; every access must satisfy aligned_adr + 8 <= MEM_BYTES.
- XLEN, 64, data and address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 B, 01 H, 10 W, 11 D.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_done  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  load result; valid while resp_done = 1.
- resp_fault  out  1  misaligned or out-of-range; valid while resp_done = 1.
- mem_adr  out  XLEN  to memory adr; always a multiple of 8.
- mem_datain  out  XLEN  to memory datain.
- mem_w  out  1  memory write enable.
- mem_r  out  1  memory read enable.
- mem_dataout  in  XLEN  from memory dataout; combinational, z when mem_r = 0.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - req_ready = 1.
  - resp_done, resp_fault, mem_w, mem_r = 0.
  - mem_adr, mem_datain, resp_rdata = 0.
- Reset takes effect immediately, including mid-operation: a pending write is aborted and no resp_done is produced.
- Accept: on a rising edge with state = IDLE and req_valid = 1, latch all req_* fields. req_ready = (state == IDLE), as a registered-state decode.
- Derived values:
  - lane = addr[2:0].
  - aligned = {addr[63:3], 3'b000}.
  - nbytes = 1 << size.
- Fault (checked at accept):
  - condition: (lane mod nbytes) != 0, or aligned + 8 > MEM_BYTES.
  - action: go directly to RESP with resp_fault = 1 and resp_rdata = 0.
  - no memory access is made.
- States and transitions:
  - IDLE -> FAULT path to RESP; load -> RD; store with size D -> WR; store with size < D -> RMW_RD.
  - RD: mem_r = 1, mem_adr = aligned. At the edge, capture extract(mem_dataout) into resp_rdata, then go to RESP.
  - RMW_RD: mem_r = 1. At the edge, capture merged = mem_dataout with bytes [lane +: nbytes] replaced by wdata[8*nbytes-1:0], into mem_datain. Go to RMW_WR.
  - WR (size D): mem_w = 1, mem_datain = wdata; the memory writes at the end of the cycle. Go to RESP.
  - RMW_WR: mem_w = 1, mem_datain = merged. Go to RESP.
  - RESP: resp_done = 1 for exactly one cycle, then IDLE.
- Extract: field = mem_dataout[8*lane +: 8*nbytes]; sign- or zero-extend per req_unsigned. Size D ignores req_unsigned.
- mem_r and mem_w are never 1 in the same cycle.
- Outside the RD, RMW_RD, WR and RMW_WR states, mem_r = mem_w = 0.
- mem_adr holds its last value when idle.
- Latency from the accept edge to resp_done high:
  - load: 2 cycles.
  - D store: 2 cycles.
  - sub-D store: 3 cycles.
  - fault: 1 cycle.
- A request can be accepted in the cycle after RESP, so back-to-back throughput is one request per (latency + 1) cycles.
- resp_rdata holds its value until the next load completes. For stores it is 0.

Test Plan:
- Memory bytes: [0] = 0x14, [2] = 0x32, [12] = 0x64, all others 0. Load D at addr 0 -> resp_rdata = 0x0000_0000_0032_0014, resp_fault = 0, done 2 cycles after accept.
- Load B at addr 12, unsigned = 0 -> rdata = 0x64. Then store B 0xF0 at addr 12 (3 cycles, mem_r cycle then mem_w cycle, mem_adr = 8). Then load B signed at addr 12 -> 0xFFFF_FFFF_FFFF_FFF0; load B unsigned -> 0xF0.
- Store H 0xBEEF at addr 2 -> memory bytes [2] = 0xEF, [3] = 0xBE, bytes [0] = 0x14 and [1..7] otherwise unchanged. Load W at addr 0 -> 0xBEEF_0014.
- Load H at addr 3 -> resp_fault = 1, rdata = 0, done 1 cycle after accept, no mem_r or mem_w pulse. Load D at addr 32 (MEM_BYTES = 32) -> fault.
- Store D at addr 24 -> single mem_w cycle with mem_adr = 24. Drop rst_n low during RMW_RD of a store H at addr 16 -> mem_w never asserts, bytes 16..23 unchanged, req_ready = 1 immediately.
- Hold req_valid = 1 continuously with alternating load and store -> req_ready low from accept through RESP, no request lost or duplicated, one resp_done per request.
